// File: rtl/serial_shift_unit.sv
// Iterative SLL/SRA/SRL shifter with start/valid handshake, one step per cycle.
// Define SERIAL_SHIFT_FAST4_EN to move 4 positions per step while cnt >= 4.
module serial_shift_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             ctrl_start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] operand,
    input  logic [4:0]       shamt,
    output logic [WIDTH-1:0] result,
    output logic             result_valid,
    output logic             busy
);

    localparam logic [1:0] OP_SLL  = 2'b00;
    localparam logic [1:0] OP_SRA  = 2'b01;
    localparam logic [1:0] OP_SRL  = 2'b10;
    localparam logic [1:0] OP_PASS = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_acc;
    logic [4:0]       r_cnt;
    logic [1:0]       r_op;
    logic [WIDTH-1:0] r_result;

    logic             w_accept;
    logic             w_start_done;
    logic             w_four;
    logic [WIDTH-1:0] w_acc_step;
    logic [4:0]       w_cnt_step;

    // One shift step; f_four selects a 4-position move instead of 1.
    function automatic logic [WIDTH-1:0] shift_step(
        input logic [1:0]       f_op,
        input logic [WIDTH-1:0] f_acc,
        input logic             f_four
    );
        logic [WIDTH-1:0] v;
        v = f_acc;
        case (f_op)
            OP_SLL: v = f_four ? {f_acc[WIDTH-5:0], 4'b0000}
                               : {f_acc[WIDTH-2:0], 1'b0};
            OP_SRA: v = f_four ? {{4{f_acc[WIDTH-1]}}, f_acc[WIDTH-1:4]}
                               : {f_acc[WIDTH-1], f_acc[WIDTH-1:1]};
            OP_SRL: v = f_four ? {4'b0000, f_acc[WIDTH-1:4]}
                               : {1'b0, f_acc[WIDTH-1:1]};
            default: v = f_acc;
        endcase
        return v;
    endfunction

`ifdef SERIAL_SHIFT_FAST4_EN
    assign w_four = (r_cnt >= 5'd4);
`else
    assign w_four = 1'b0;
`endif

    assign w_accept     = ctrl_start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_start_done = (shamt == 5'd0) || (op == OP_PASS);
    assign w_acc_step   = shift_step(r_op, r_acc, w_four);
    assign w_cnt_step   = r_cnt - (w_four ? 5'd4 : 5'd1);

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (ctrl_start) begin
                    w_state_next = w_start_done ? ST_DONE : ST_SHIFT;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (w_cnt_step == 5'd0) begin
                    w_state_next = ST_DONE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        result_valid = (r_state == ST_DONE);
        busy         = (r_state == ST_SHIFT);
        result       = r_result;
    end

    // Working registers need no reset: they are always loaded at accept.
    always_ff @(posedge clock) begin
        if (w_accept) begin
            r_acc <= operand;
            r_cnt <= shamt;
            r_op  <= op;
        end else if (r_state == ST_SHIFT) begin
            r_acc <= w_acc_step;
            r_cnt <= w_cnt_step;
        end
    end

    // Result only changes on entry to DONE, so it holds through IDLE and SHIFT.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_result <= '0;
        end else if (w_state_next == ST_DONE) begin
            r_result <= w_accept ? operand : w_acc_step;
        end
    end

endmodule
